// File: rtl/hood_mode_fsm_pkg.sv
// Shared mode encodings and the mode enum for the exhaust-hood control slice.
// Macros: `MODE_WIDTH and the `*_MODE codes are the single source of the mode
// encoding for every per-mode controller; the package wraps them in mode_t.
`ifndef HOOD_PARAMETERS_VH
`define HOOD_PARAMETERS_VH
`define MODE_WIDTH  3
`define OFF_MODE    3'd0
`define STAND_MODE  3'd1
`define FIRST_MODE  3'd2
`define SECOND_MODE 3'd3
`define THIRD_MODE  3'd4
`endif

package hood_mode_fsm_pkg;

  typedef enum logic [`MODE_WIDTH-1:0] {
    MODE_OFF    = `OFF_MODE,
    MODE_STAND  = `STAND_MODE,
    MODE_FIRST  = `FIRST_MODE,
    MODE_SECOND = `SECOND_MODE,
    MODE_THIRD  = `THIRD_MODE
  } mode_t;

endpackage

// File: rtl/hood_mode_fsm_button_edge_detect.sv
// Rising-edge (press) detector for one debounced panel key.
// Ports: clk, rstn (async active-low), btn (debounced level), press (combinational
// btn & ~history). History resets to 1 so a key held through reset gives no press.
module button_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic press
);

  logic btn_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) btn_d <= 1'b1;
    else       btn_d <= btn;
  end

  assign press = btn & ~btn_d;

endmodule

// File: rtl/hood_mode_fsm.sv
// Central mode register of the exhaust hood; sole driver of current_mode.
// Ports: clk, rstn (async active-low), five debounced key levels, the third-mode
// expiry level; registered current_mode, menu_active, third_used, mode_changed.
// Optional macro HURRICANE_ONCE_EN: THIRD may be entered only once per power cycle.
module hood_mode_fsm
  import hood_mode_fsm_pkg::*;
#(
  parameter int MENU_TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   power_btn,
  input  logic                   menu_btn,
  input  logic                   first_btn,
  input  logic                   second_btn,
  input  logic                   third_btn,
  input  logic                   stand_from_third_toggle,
  output logic [`MODE_WIDTH-1:0] current_mode,
  output logic                   menu_active,
  output logic                   third_used,
  output logic                   mode_changed
);

  localparam int CNT_W = (MENU_TIMEOUT_CYCLES > 2) ? $clog2(MENU_TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MENU_TIMEOUT_CYCLES - 1);

  logic power_press, menu_press, first_press, second_press, third_press;

  button_edge_detect u_power  (.clk(clk), .rstn(rstn), .btn(power_btn),  .press(power_press));
  button_edge_detect u_menu   (.clk(clk), .rstn(rstn), .btn(menu_btn),   .press(menu_press));
  button_edge_detect u_first  (.clk(clk), .rstn(rstn), .btn(first_btn),  .press(first_press));
  button_edge_detect u_second (.clk(clk), .rstn(rstn), .btn(second_btn), .press(second_press));
  button_edge_detect u_third  (.clk(clk), .rstn(rstn), .btn(third_btn),  .press(third_press));

  mode_t            mode, nxt_mode;
  logic [CNT_W-1:0] menu_cnt, nxt_cnt;
  logic             nxt_menu, nxt_third_used, third_ok;

`ifdef HURRICANE_ONCE_EN
  // A blocked third press is simply not an applicable event, so the menu stays open.
  assign third_ok = ~third_used;
`else
  assign third_ok = 1'b1;
`endif

  always_comb begin
    nxt_mode = mode;
    nxt_menu = menu_active;
    nxt_cnt  = menu_cnt;

    // Menu window ageing; any event below overrides it.
    if (menu_active) begin
      if (menu_cnt == CNT_LAST) begin
        nxt_menu = 1'b0;
        nxt_cnt  = '0;
      end else begin
        nxt_cnt = menu_cnt + 1'b1;
      end
    end

    // Priority: power > stand request > menu > third > second > first.
    unique case (mode)
      MODE_OFF: begin
        if (power_press) nxt_mode = MODE_STAND;
      end
      MODE_STAND: begin
        if (power_press) begin
          nxt_mode = MODE_OFF;
        end else if (menu_press) begin
          nxt_menu = 1'b1;
          nxt_cnt  = '0;
        end else if (menu_active) begin
          if (third_press && third_ok) nxt_mode = MODE_THIRD;
          else if (second_press)       nxt_mode = MODE_SECOND;
          else if (first_press)        nxt_mode = MODE_FIRST;
        end
      end
      MODE_FIRST: begin
        if (power_press)       nxt_mode = MODE_OFF;
        else if (menu_press)   nxt_mode = MODE_STAND;
        else if (second_press) nxt_mode = MODE_SECOND;
      end
      MODE_SECOND: begin
        if (power_press)      nxt_mode = MODE_OFF;
        else if (menu_press)  nxt_mode = MODE_STAND;
        else if (first_press) nxt_mode = MODE_FIRST;
      end
      MODE_THIRD: begin
        if (power_press)                  nxt_mode = MODE_OFF;
        else if (stand_from_third_toggle) nxt_mode = MODE_STAND;
      end
      default: nxt_mode = MODE_OFF;
    endcase

    // The menu window only exists in STANDBY; covers OFF entry and speed selection.
    if (nxt_mode != MODE_STAND) begin
      nxt_menu = 1'b0;
      nxt_cnt  = '0;
    end

    nxt_third_used = third_used;
    if (nxt_mode == MODE_THIRD && mode != MODE_THIRD) nxt_third_used = 1'b1;
    if (nxt_mode == MODE_OFF && mode != MODE_OFF)     nxt_third_used = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode         <= MODE_OFF;
      menu_active  <= 1'b0;
      menu_cnt     <= '0;
      third_used   <= 1'b0;
      mode_changed <= 1'b0;
    end else begin
      mode         <= nxt_mode;
      menu_active  <= nxt_menu;
      menu_cnt     <= nxt_cnt;
      third_used   <= nxt_third_used;
      mode_changed <= (nxt_mode != mode);
    end
  end

  assign current_mode = mode;

endmodule

// File: tb/tb_hood_mode_fsm.sv
module tb_hood_mode_fsm;

  localparam int N = 8;
  localparam logic [2:0] M_OFF = 3'd0, M_STB = 3'd1, M_FST = 3'd2, M_SEC = 3'd3, M_THR = 3'd4;
`ifdef HURRICANE_ONCE_EN
  localparam bit ONCE = 1'b1;
`else
  localparam bit ONCE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic power_btn = 1'b0, menu_btn = 1'b0, first_btn = 1'b0;
  logic second_btn = 1'b0, third_btn = 1'b0, stand_from_third_toggle = 1'b0;
  logic [2:0] current_mode;
  logic menu_active, third_used, mode_changed;

  hood_mode_fsm #(.MENU_TIMEOUT_CYCLES(N)) dut (
    .clk(clk), .rstn(rstn),
    .power_btn(power_btn), .menu_btn(menu_btn), .first_btn(first_btn),
    .second_btn(second_btn), .third_btn(third_btn),
    .stand_from_third_toggle(stand_from_third_toggle),
    .current_mode(current_mode), .menu_active(menu_active),
    .third_used(third_used), .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, m, f, s, t, st);
    power_btn = p; menu_btn = m; first_btn = f;
    second_btn = s; third_btn = t; stand_from_third_toggle = st;
  endtask

  task automatic check_all(input string tag, input logic [2:0] mode, input logic menu,
                           input logic tu, input logic chg);
    check({tag, ".mode"}, 32'(current_mode), 32'(mode));
    check({tag, ".menu"}, 32'(menu_active), 32'(menu));
    check({tag, ".third_used"}, 32'(third_used), 32'(tu));
    check({tag, ".changed"}, 32'(mode_changed), 32'(chg));
  endtask

  typedef struct {
    logic p, m, f, s, t, st;
    logic [2:0] mode;
    logic menu, tu, chg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic p, m, f, s, t, st,
                              input logic [2:0] mode, input logic menu, tu, chg);
    vec_t v;
    v.p = p; v.m = m; v.f = f; v.s = s; v.t = t; v.st = st;
    v.mode = mode; v.menu = menu; v.tu = tu; v.chg = chg;
    vecs.push_back(v);
  endfunction

  int cnt;

  initial begin
    //   p  m  f  s  t  st   mode   menu tu chg
    add(1, 0, 0, 0, 0, 0,  M_STB, 0, 0, 1);   // power on, first sample
    add(1, 0, 0, 0, 0, 0,  M_STB, 0, 0, 0);   // held: no new press
    add(1, 0, 0, 0, 0, 0,  M_STB, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  M_STB, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  M_OFF, 0, 0, 1);   // power off
    add(0, 0, 0, 0, 0, 0,  M_OFF, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  M_OFF, 0, 0, 0);   // menu ignored in OFF
    add(0, 0, 0, 0, 0, 0,  M_OFF, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  M_STB, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  M_STB, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  M_STB, 1, 0, 0);   // open menu
    add(0, 0, 0, 0, 0, 0,  M_STB, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  M_SEC, 0, 0, 1);   // second selects SECOND
    add(0, 0, 0, 0, 0, 0,  M_SEC, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  M_FST, 0, 0, 1);   // SECOND -> FIRST
    add(0, 0, 0, 0, 0, 0,  M_FST, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,  M_FST, 0, 0, 0);   // third ignored in FIRST
    add(0, 0, 0, 0, 0, 0,  M_FST, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  M_STB, 0, 0, 1);   // menu -> STANDBY, window closed
    add(0, 0, 0, 0, 0, 0,  M_STB, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  M_STB, 0, 0, 0);   // speed ignored without menu
    add(0, 0, 0, 0, 0, 0,  M_STB, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  M_STB, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  M_STB, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0,  M_THR, 0, 1, 1);   // first+third: third wins
    add(0, 0, 0, 0, 0, 0,  M_THR, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  M_THR, 0, 1, 0);   // menu ignored in THIRD
    add(0, 0, 0, 0, 0, 0,  M_THR, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,  M_STB, 0, 1, 1);   // expiry -> STANDBY
    add(0, 0, 0, 0, 0, 0,  M_STB, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,  M_STB, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,  M_STB, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0,  ONCE ? M_STB : M_THR, ONCE, 1, !ONCE);
    add(0, 0, 0, 0, 0, 0,  ONCE ? M_STB : M_THR, ONCE, 1, 0);
    add(1, 0, 0, 0, 0, 1,  M_OFF, 0, 0, 1);   // power beats stand request
    add(0, 0, 0, 0, 0, 0,  M_OFF, 0, 0, 0);

    // Reset state
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    check_all("reset", M_OFF, 0, 0, 0);
    rstn = 1'b1;
    tick();   // idle cycle so history learns the released keys

    foreach (vecs[i]) begin
      drive(vecs[i].p, vecs[i].m, vecs[i].f, vecs[i].s, vecs[i].t, vecs[i].st);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].mode, vecs[i].menu, vecs[i].tu, vecs[i].chg);
    end

    // Simultaneous power + stand request while in THIRD
    drive(1, 0, 0, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    check_all("thr_enter", M_THR, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 1); tick();
    check_all("thr_pwr_stand", M_OFF, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0); tick();

    // Menu timeout: window open for exactly N cycles
    drive(1, 0, 0, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0, 0); tick();
    cnt = 0;
    drive(0, 1, 0, 0, 0, 0); tick();
    if (menu_active) cnt++;
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (menu_active) cnt++;
    end
    check("timeout_len", 32'(cnt), 32'(N));
    check("timeout_closed", 32'(menu_active), 32'd0);
    drive(0, 0, 1, 0, 0, 0); tick();
    check_all("timeout_first_ignored", M_STB, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0); tick();

    // Repeated menu press restarts the window
    drive(0, 1, 0, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    check("menu_mid", 32'(menu_active), 32'd1);
    drive(0, 1, 0, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (menu_active) cnt++;
    end
    check("restart_len", 32'(cnt), 32'(N - 1));

    // Async reset in SECOND with third and power held through release
    drive(0, 1, 0, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); tick(); drive(0, 0, 0, 0, 0, 0); tick();
    check("pre_reset_mode", 32'(current_mode), 32'(M_SEC));
    drive(1, 0, 0, 0, 1, 0);
    #2 rstn = 1'b0;
    #1 check_all("async_reset", M_OFF, 0, 0, 0);
    tick();
    rstn = 1'b1;
    tick(); tick();
    check_all("held_keys_no_press", M_OFF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0); tick();
    check_all("post_reset_power", M_STB, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hood_mode_fsm.md
Name: hood_mode_fsm

Overview:
- Central mode register of the exhaust hood; sole driver of `current_mode` for every per-mode controller.
- Consumes debounced panel buttons (power, menu, first/second/third speed) from the debouncers.
- Consumes the return-to-stand request produced by the third-mode countdown controller and moves the hood to STANDBY on it.
- Sits between the debouncer bank (upstream) and the per-mode timer controllers and display logic (downstream).

Parameters:
MENU_TIMEOUT_CYCLES, 500_000_000, menu window length in clk cycles (5 s at 100 MHz); must be >= 2; benches override it small.

Ports:
clk  in  1  100 MHz system clock.
rstn  in  1  asynchronous active-low reset.
power_btn  in  1  debounced level, power key.
menu_btn  in  1  debounced level, menu key.
first_btn  in  1  debounced level, first-speed key.
second_btn  in  1  debounced level, second-speed key.
third_btn  in  1  debounced level, third-speed (hurricane) key.
stand_from_third_toggle  in  1  level from the third-mode countdown controller; high = third-mode time expired.
current_mode  out  `MODE_WIDTH  registered current mode.
menu_active  out  1  registered; high while the speed-selection window is open.
third_used  out  1  registered; high once THIRD has been entered in this power cycle.
mode_changed  out  1  one-cycle registered pulse.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; ports named clk and rstn.
- Reset values: current_mode=`OFF_MODE; menu_active=0; third_used=0; mode_changed=0; menu counter=0; all button-history registers=1.
  - History reset to 1 means a button held through reset release produces no press.
- Press: press_x = x_btn & ~x_btn_d. The effect is registered on the same clk edge at which press_x is high, so current_mode shows the new value one cycle after the button is first sampled high.
- Priority within one cycle, highest first: power press, stand_from_third_toggle, menu press, speed press. Among speed presses: third > second > first. Only the highest applicable event acts; the rest are dropped.
- OFF:
  - power -> STANDBY.
  - All other inputs ignored.
- STANDBY:
  - power -> OFF.
  - menu -> menu_active=1, counter cleared.
  - With menu_active=1: first -> FIRST; second -> SECOND; third -> THIRD, unless it is blocked (see Optional Feature).
  - Any speed transition clears menu_active.
  - Speed presses with menu_active=0 are ignored.
- FIRST / SECOND:
  - power -> OFF.
  - menu -> STANDBY.
  - FIRST: second -> SECOND. SECOND: first -> FIRST.
  - third press ignored.
- THIRD:
  - power -> OFF.
  - stand_from_third_toggle=1 -> STANDBY.
  - menu and speed presses ignored.
- Menu window:
  - Counter increments each cycle while menu_active=1.
  - A repeated menu press clears the counter.
  - When counter == MENU_TIMEOUT_CYCLES-1, menu_active drops on the next edge and the counter clears; mode stays STANDBY.
  - Leaving STANDBY for any reason clears menu_active and the counter.
- third_used: set on the edge that enters THIRD; cleared on the edge that enters OFF.
- mode_changed: high for exactly the first cycle in which current_mode holds a new value. Never high for a self-transition.
- Entering OFF from any state forces menu_active=0 on that same edge.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: HURRICANE_ONCE_EN.
- Defined: THIRD is entered at most once per power cycle. A third press while third_used=1 is ignored and the menu stays open.
- Undefined: THIRD is re-enterable without limit; third_used is still tracked as specified above (informational only).

Decomposition:
- Shared header parameters.vh holds `MODE_WIDTH (3) and the mode codes `OFF_MODE=0, `STAND_MODE=1, `FIRST_MODE=2, `SECOND_MODE=3, `THIRD_MODE=4. No encodings are defined locally.
- One natural sub-module: button_edge_detect, a one-bit history register (reset to 1) with press output. Instantiated five times.

Test Plan:
- Power-up: after reset, power_btn high 3 cycles -> current_mode 0->1 one cycle after first sample, mode_changed pulses once, second press of power -> 0.
- Menu select: STANDBY, menu press, then second press 10 cycles later -> current_mode=3, menu_active=0; then first press -> 2; then menu press -> 1.
- Menu timeout, MENU_TIMEOUT_CYCLES=8: menu press with no further input -> menu_active high exactly 8 cycles, then 0; a later first press is ignored (mode stays 1).
- Third cycle: menu+third -> mode 4, third_used=1; drive stand_from_third_toggle high -> mode 1 next cycle.
  - With HURRICANE_ONCE_EN: menu+third again -> mode stays 1, menu_active stays 1.
  - Without the macro: mode -> 4.
- Simultaneous events: in THIRD, power press and stand_from_third_toggle on the same cycle -> mode 0, third_used=0. In STANDBY with menu open, first+third pressed together -> mode 4.
- Reset robustness: assert rstn low while in SECOND holding third_btn high; release -> mode 0, and the held third_btn produces no press.
